// File: rtl/radix16_booth_lut.sv
// Radix-16 Booth recoder: maps a 5-bit overlapping multiplier window to sign + magnitude (0..8).
// Optional one-hot select output enabled by defining RADIX_LUT_ONEHOT_EN.
module radix16_booth_lut #(
  parameter int OUT_REG = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       In_Valid,
  input  logic [4:0] Radix,
  output logic       Out_Valid,
  output logic       Sign,
  output logic [3:0] Out,
  output logic       Zero
`ifdef RADIX_LUT_ONEHOT_EN
  ,
  output logic [8:0] Sel
`endif
);

  logic signed [4:0] digit;
  logic [3:0]        dec_out;
  logic              dec_sign;
  logic              dec_zero;
  logic [8:0]        dec_sel;

  // The top four bits read as a signed nibble give -8*r4+4*r3+2*r2+r1; the overlap bit adds r0.
  always_comb begin
    digit    = $signed({Radix[4], Radix[4:1]}) + $signed({4'b0000, Radix[0]});
    dec_out  = digit[4] ? 4'(-digit) : digit[3:0];
    dec_sign = Radix[4];
    dec_zero = (dec_out == 4'd0);
    dec_sel  = 9'b000000001 << dec_out;
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [8:0] sel_q;

      // Sign keeps Radix[4] literally, so 11111 leaves as a negative zero.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          Out_Valid <= 1'b0;
          Sign      <= 1'b0;
          Out       <= 4'd0;
          Zero      <= 1'b1;
          sel_q     <= 9'b000000001;
        end else begin
          Out_Valid <= In_Valid;
          if (In_Valid) begin
            Sign  <= dec_sign;
            Out   <= dec_out;
            Zero  <= dec_zero;
            sel_q <= dec_sel;
          end
        end
      end

`ifdef RADIX_LUT_ONEHOT_EN
      assign Sel = sel_q;
`endif
    end else begin : g_comb
      assign Out_Valid = In_Valid;
      assign Sign      = dec_sign;
      assign Out       = dec_out;
      assign Zero      = dec_zero;
`ifdef RADIX_LUT_ONEHOT_EN
      assign Sel       = dec_sel;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_radix16_booth_lut.sv
// Scoreboard bench for radix16_booth_lut: stimulus pushes expected decodes, a negedge monitor pops them.
// Covers the Sel port as well when RADIX_LUT_ONEHOT_EN is defined.
module tb_radix16_booth_lut;

  typedef struct packed {
    logic       sign;
    logic [3:0] out;
  } exp_t;

  logic       Clk;
  logic       Reset;
  logic       In_Valid;
  logic [4:0] Radix;
  logic       Out_Valid;
  logic       Sign;
  logic [3:0] Out;
  logic       Zero;
`ifdef RADIX_LUT_ONEHOT_EN
  logic [8:0] Sel;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  // Hand-computed |d| for every code; sign is simply the top bit of the code.
  logic [3:0] mag_table [32] = '{
    4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4,
    4'd4, 4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd7, 4'd8,
    4'd8, 4'd7, 4'd7, 4'd6, 4'd6, 4'd5, 4'd5, 4'd4,
    4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0
  };

  radix16_booth_lut #(.OUT_REG(1)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .In_Valid  (In_Valid),
    .Radix     (Radix),
    .Out_Valid (Out_Valid),
    .Sign      (Sign),
    .Out       (Out),
    .Zero      (Zero)
`ifdef RADIX_LUT_ONEHOT_EN
    ,
    .Sel       (Sel)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_output(input string name, input logic [8:0] actual, input logic [8:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] code, input logic [3:0] mag);
    exp_t e;
    @(posedge Clk);
    #1;
    Radix    = code;
    In_Valid = 1'b1;
    e.sign   = code[4];
    e.out    = mag;
    sb_q.push_back(e);
  endtask

  task automatic go_idle();
    @(posedge Clk);
    #1;
    In_Valid = 1'b0;
  endtask

  // Monitor: every valid output must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset && Out_Valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid: got Out=%0d Sign=%0b expected no output", Out, Sign);
      end else begin
        e = sb_q.pop_front();
        check_output("sign", {8'd0, Sign}, {8'd0, e.sign});
        check_output("out",  {5'd0, Out},  {5'd0, e.out});
        check_output("zero", {8'd0, Zero}, {8'd0, (e.out == 4'd0)});
`ifdef RADIX_LUT_ONEHOT_EN
        check_output("sel", Sel, 9'b000000001 << e.out);
`endif
      end
    end
  end

  initial begin
    Reset    = 1'b1;
    In_Valid = 1'b0;
    Radix    = 5'd0;
    #3;
    check_output("reset_valid", {8'd0, Out_Valid}, 9'd0);
    check_output("reset_out",   {5'd0, Out},       9'd0);
    check_output("reset_zero",  {8'd0, Zero},      9'd1);
    check_output("reset_sign",  {8'd0, Sign},      9'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Asynchronous reset while a valid digit of magnitude 5 is presented.
    apply_stimulus(5'b01010, 4'd5);
    go_idle();
    @(negedge Clk);
    #2;
    check_output("pre_reset_valid", {8'd0, Out_Valid}, 9'd1);
    check_output("pre_reset_out",   {5'd0, Out},       9'd5);
    Reset = 1'b1;
    #1;
    check_output("async_valid", {8'd0, Out_Valid}, 9'd0);
    check_output("async_out",   {5'd0, Out},       9'd0);
    check_output("async_zero",  {8'd0, Zero},      9'd1);
    check_output("async_sign",  {8'd0, Sign},      9'd0);
`ifdef RADIX_LUT_ONEHOT_EN
    check_output("async_sel", Sel, 9'b000000001);
`endif
    #1;
    Reset = 1'b0;
    apply_stimulus(5'b00011, 4'd2);

    // Full sweep, one code per cycle.
    for (int i = 0; i < 32; i++) apply_stimulus(5'(i), mag_table[i]);

    // Pair equivalence.
    apply_stimulus(5'b00111, 4'd4);
    apply_stimulus(5'b01000, 4'd4);
    apply_stimulus(5'b10111, 4'd4);
    apply_stimulus(5'b11000, 4'd4);
    apply_stimulus(5'b10110, 4'd5);
    go_idle();

    // Hold during a 3-cycle gap with Radix wandering.
    apply_stimulus(5'b01101, 4'd7);
    go_idle();
    for (int g = 0; g < 3; g++) begin
      @(posedge Clk);
      #1;
      Radix = 5'($urandom_range(0, 31));
      @(negedge Clk);
      check_output("gap_valid", {8'd0, Out_Valid}, 9'd0);
      check_output("gap_out",   {5'd0, Out},       9'd7);
      check_output("gap_sign",  {8'd0, Sign},      9'd0);
    end

    // Back-to-back corner codes.
    apply_stimulus(5'b00000, 4'd0);
    apply_stimulus(5'b11111, 4'd0);
    apply_stimulus(5'b01111, 4'd8);
    apply_stimulus(5'b10000, 4'd8);
    apply_stimulus(5'b01011, 4'd6);
    go_idle();

    repeat (4) @(posedge Clk);
    @(negedge Clk);
    check_output("queue_drained", 9'(sb_q.size()), 9'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
